// File: rtl/pattern_checker.sv
// Pattern checker for a memory game.
// The controller first loads a nibble sequence (up to 16 entries), then the
// player replays it one guess at a time. A wrong guess latches loseSig until
// restart; a complete replay pulses done for one cycle.
module pattern_checker (
    input  logic       clka,
    input  logic       resetn,
    input  logic       loadData,
    input  logic       readData,
    input  logic       restart,
    input  logic       dataValid,
    input  logic [3:0] dataIn,
    output logic       loseSig,
    output logic       done,
    output logic       full,
    output logic [3:0] expected,
    output logic [4:0] length,
    output logic [4:0] matchCount
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCheck,
        StLost
    } state_e;

    localparam int unsigned Depth = 16;

    state_e     state;
    logic [3:0] mem [Depth];
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;

    // Decoded per-cycle actions; restart and reset suppress all of them.
    logic write_en;
    logic replay_done;
    logic guess;
    logic hit;
    logic last_hit;

    // Decode which memory write or compare happens this cycle.
    always_comb begin
        write_en    = resetn && !restart && (state == StLoad) && dataValid && !full;
        replay_done = (matchCount == length);
        guess       = !restart && (state == StCheck) && dataValid && !replay_done;
        hit         = guess && (dataIn == mem[rd_ptr]);
        last_hit    = hit && ((matchCount + 5'd1) == length);
    end

    // Pattern storage; contents deliberately survive reset and restart.
    always_ff @(posedge clka) begin
        if (write_en) begin
            mem[wr_ptr] <= dataIn;
        end
    end

    // Game FSM with registered outputs and pointers.
    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            state      <= StIdle;
            loseSig    <= 1'b0;
            done       <= 1'b0;
            full       <= 1'b0;
            expected   <= 4'd0;
            length     <= 5'd0;
            matchCount <= 5'd0;
            wr_ptr     <= 4'd0;
            rd_ptr     <= 4'd0;
        end else begin
            done <= 1'b0;

            // Display copy tracks the replay pointer only while checking.
            if (state == StCheck) begin
                expected <= mem[rd_ptr];
            end

            if (restart) begin
                state      <= StIdle;
                loseSig    <= 1'b0;
                full       <= 1'b0;
                length     <= 5'd0;
                matchCount <= 5'd0;
                wr_ptr     <= 4'd0;
                rd_ptr     <= 4'd0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (loadData) begin
                            state  <= StLoad;
                            wr_ptr <= 4'd0;
                            length <= 5'd0;
                            full   <= 1'b0;
                        end else if (readData) begin
                            state      <= StCheck;
                            rd_ptr     <= 4'd0;
                            matchCount <= 5'd0;
                            // An empty pattern is trivially matched.
                            if (length == 5'd0) begin
                                done <= 1'b1;
                            end
                        end
                    end

                    StLoad: begin
                        if (write_en) begin
                            length <= length + 5'd1;
                            // Hold the pointer on the last slot instead of wrapping.
                            if (length == 5'(Depth - 1)) begin
                                full <= 1'b1;
                            end else begin
                                wr_ptr <= wr_ptr + 4'd1;
                            end
                        end
                        if (!loadData) begin
                            state <= StIdle;
                        end
                    end

                    StCheck: begin
                        if (replay_done) begin
                            // Only reachable on entry with an empty pattern.
                            state <= StIdle;
                        end else if (guess) begin
                            if (hit) begin
                                matchCount <= matchCount + 5'd1;
                                if (last_hit) begin
                                    done  <= 1'b1;
                                    state <= StIdle;
                                end else begin
                                    rd_ptr <= rd_ptr + 4'd1;
                                    if (!readData) begin
                                        state <= StIdle;
                                    end
                                end
                            end else begin
                                loseSig <= 1'b1;
                                state   <= StLost;
                            end
                        end else if (!readData) begin
                            state <= StIdle;
                        end
                    end

                    StLost: begin
                        loseSig <= 1'b1;
                    end

                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    // A win and a loss can never be reported together.
    always_ff @(posedge clka) begin
        if (resetn) begin
            assert (!(done && loseSig));
        end
    end
`endif

endmodule

// File: tb/tb_pattern_checker.sv
// Randomised scoreboard bench for pattern_checker.
module tb_pattern_checker;

    logic       clka = 1'b0;
    logic       resetn = 1'b0;
    logic       loadData = 1'b0;
    logic       readData = 1'b0;
    logic       restart = 1'b0;
    logic       dataValid = 1'b0;
    logic [3:0] dataIn = 4'd0;
    logic       loseSig;
    logic       done;
    logic       full;
    logic [3:0] expected;
    logic [4:0] length;
    logic [4:0] matchCount;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit is_done;
        int mc;
        int len;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    logic       lose_prev = 1'b0;

    // Reference model: the stored pattern and replay progress.
    logic [3:0] pat[$];
    int         mc = 0;
    bit         lost = 0;

    // Stimulus buffers.
    logic [3:0] seq[$];
    logic [3:0] gq[$];

    always #5 clka = ~clka;

    pattern_checker dut (
        .clka       (clka),
        .resetn     (resetn),
        .loadData   (loadData),
        .readData   (readData),
        .restart    (restart),
        .dataValid  (dataValid),
        .dataIn     (dataIn),
        .loseSig    (loseSig),
        .done       (done),
        .full       (full),
        .expected   (expected),
        .length     (length),
        .matchCount (matchCount)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clka);
        #1;
    endtask

    task automatic push_ev(input bit d, input int m, input int l);
        ev_t e;
        e.is_done = d;
        e.mc      = m;
        e.len     = l;
        exp_q.push_back(e);
    endtask

    // Monitor: every done pulse or loseSig rise must match a predicted event.
    always @(negedge clka) begin
        if (done || (loseSig && !lose_prev)) begin
            if (done && loseSig) begin
                n_checks++;
                n_errors++;
                $display("FAIL done_with_lose: done=%0b loseSig=%0b, want not both", done, loseSig);
            end
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_event: done=%0b loseSig=%0b, want no event", done, loseSig);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_done", 32'(done), 32'(mon_e.is_done));
                chk("event_matchCount", 32'(matchCount), mon_e.mc);
                chk("event_length", 32'(length), mon_e.len);
            end
        end
        lose_prev = loseSig;
    end

    task automatic do_load(input bit with_read);
        loadData = 1'b1;
        readData = with_read;
        tick();
        readData = 1'b0;
        pat.delete();
        foreach (seq[i]) begin
            dataIn    = seq[i];
            dataValid = 1'b1;
            tick();
            dataValid = 1'b0;
            if (pat.size() < 16) pat.push_back(seq[i]);
            chk("load_length", 32'(length), pat.size());
            chk("load_full", 32'(full), 32'(pat.size() == 16));
            tick();
        end
        loadData = 1'b0;
        tick();
        chk("load_exit_length", 32'(length), pat.size());
    endtask

    // Replays gq; drop_last lowers readData with the final guess, leave
    // lowers it once the guesses are done.
    task automatic do_replay(input bit drop_last, input bit leave);
        readData = 1'b1;
        tick();
        mc = 0;
        if (pat.size() == 0) begin
            push_ev(1'b1, 0, 0);
            readData = 1'b0;
            tick();
            return;
        end
        foreach (gq[i]) begin
            tick();
            chk("expected", 32'(expected), 32'(pat[mc]));
            dataIn    = gq[i];
            dataValid = 1'b1;
            if (drop_last && i == gq.size() - 1) readData = 1'b0;
            tick();
            dataValid = 1'b0;
            if (gq[i] == pat[mc]) begin
                mc++;
                if (mc == pat.size()) push_ev(1'b1, mc, pat.size());
            end else begin
                lost = 1;
                push_ev(1'b0, mc, pat.size());
            end
            chk("matchCount", 32'(matchCount), mc);
            if (lost || mc == pat.size()) break;
        end
        if (leave) begin
            readData = 1'b0;
            tick();
        end
    endtask

    task automatic do_restart;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        pat.delete();
        mc   = 0;
        lost = 0;
        chk("restart_loseSig", 32'(loseSig), 0);
        chk("restart_length", 32'(length), 0);
        chk("restart_matchCount", 32'(matchCount), 0);
        chk("restart_full", 32'(full), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #12;
        chk("rst_loseSig", 32'(loseSig), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_expected", 32'(expected), 0);
        chk("rst_length", 32'(length), 0);
        chk("rst_matchCount", 32'(matchCount), 0);
        @(posedge clka);
        #1;
        resetn = 1'b1;
        tick();

        // Load 3,7,1 and replay it correctly.
        seq = '{4'd3, 4'd7, 4'd1};
        do_load(1'b0);
        gq = '{4'd3, 4'd7, 4'd1};
        do_replay(1'b1, 1'b1);
        chk("win_loseSig", 32'(loseSig), 0);

        // Mismatch on the second guess, then ignored inputs while lost.
        seq = '{4'd5, 4'd9};
        do_load(1'b0);
        gq = '{4'd5, 4'd2};
        do_replay(1'b0, 1'b1);
        chk("lost_loseSig", 32'(loseSig), 1);
        dataValid = 1'b1;
        dataIn    = 4'd9;
        loadData  = 1'b1;
        readData  = 1'b1;
        tick();
        dataValid = 1'b0;
        loadData  = 1'b0;
        readData  = 1'b0;
        tick();
        chk("lost_hold_loseSig", 32'(loseSig), 1);
        chk("lost_hold_matchCount", 32'(matchCount), 1);
        chk("lost_hold_length", 32'(length), 2);
        do_restart();

        // Overfill with 0..F,A,B, then replay all 16 entries.
        seq.delete();
        for (int i = 0; i < 16; i++) seq.push_back(4'(i));
        seq.push_back(4'hA);
        seq.push_back(4'hB);
        do_load(1'b0);
        gq.delete();
        for (int i = 0; i < 16; i++) gq.push_back(4'(i));
        do_replay(1'b1, 1'b1);

        // loadData and readData together select LOAD.
        seq = '{4'd6};
        do_load(1'b1);

        // Empty pattern replay.
        do_restart();
        do_replay(1'b1, 1'b1);

        // Partial replay interrupted after one match, then a full replay.
        seq = '{4'd2, 4'd4, 4'd8};
        do_load(1'b0);
        gq = '{4'd2};
        do_replay(1'b1, 1'b1);
        chk("partial_matchCount_hold", 32'(matchCount), 1);
        gq = '{4'd2, 4'd4, 4'd8};
        do_replay(1'b1, 1'b1);

        // Asynchronous reset mid-replay after two of four matches.
        seq = '{4'd1, 4'd2, 4'd3, 4'd4};
        do_load(1'b0);
        gq = '{4'd1, 4'd2};
        do_replay(1'b0, 1'b0);
        tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_loseSig", 32'(loseSig), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_full", 32'(full), 0);
        chk("arst_expected", 32'(expected), 0);
        chk("arst_length", 32'(length), 0);
        chk("arst_matchCount", 32'(matchCount), 0);
        readData = 1'b0;
        @(posedge clka);
        #1;
        resetn = 1'b1;
        pat.delete();
        mc = 0;
        tick();

        // Randomised rounds.
        for (int r = 0; r < 25; r++) begin
            int n;
            int mode;
            int k;
            n = $urandom_range(0, 18);
            seq.delete();
            for (int i = 0; i < n; i++) seq.push_back(4'($urandom_range(0, 15)));
            do_load(r % 7 == 3);
            mode = (pat.size() < 2) ? 0 : $urandom_range(0, 3);
            gq.delete();
            foreach (pat[i]) gq.push_back(pat[i]);
            case (mode)
                1: begin
                    k = $urandom_range(0, pat.size() - 1);
                    gq[k] = pat[k] ^ 4'($urandom_range(1, 15));
                    do_replay(1'b0, 1'b1);
                end
                2: begin
                    k = $urandom_range(1, pat.size() - 1);
                    while (gq.size() > k) void'(gq.pop_back());
                    do_replay(1'b1, 1'b1);
                    gq.delete();
                    foreach (pat[i]) gq.push_back(pat[i]);
                    do_replay(1'b1, 1'b1);
                end
                3: do_replay(1'b0, 1'b1);
                default: do_replay(1'b1, 1'b1);
            endcase
            if (lost || ($urandom_range(0, 3) == 0)) do_restart();
        end

        tick();
        tick();
        chk("events_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
